muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, downstream of the register file.
//  - Consumes the two source operands the register file reads for an M-extension instruction.
//  - Produces the 32-bit result plus destination index and write enable for the register-file write port.
//  - One operation in flight; the issue logic stalls on busy.

---
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero and signed-overflow results short-circuited at accept.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wr_en
);

    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            neg_q;
    logic            special_q;
    logic [XLEN-1:0] spec_q;
    logic [PW-1:0]   acc_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q;

    logic            accept_c;
    logic            iter_c;
    logic            finish_c;

    // Operand conditioning at accept: signedness, magnitudes, special cases
    logic            signed_a_c, signed_b_c, sa_c, sb_c, is_div_c;
    logic            div0_c, ovf_c, special_c, neg_c;
    logic [XLEN-1:0] abs_a_c, abs_b_c, spec_c;

    always_comb begin
        is_div_c   = funct3[2];
        signed_a_c = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        signed_b_c = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        sa_c       = signed_a_c && op_a[XLEN-1];
        sb_c       = signed_b_c && op_b[XLEN-1];
        abs_a_c    = sa_c ? ((~op_a) + XLEN'(1)) : op_a;
        abs_b_c    = sb_c ? ((~op_b) + XLEN'(1)) : op_b;
        div0_c     = is_div_c && (op_b == '0);
        ovf_c      = is_div_c && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
        special_c  = div0_c || ovf_c;
        spec_c     = '0;
        if (div0_c) begin
            spec_c = funct3[1] ? op_a : '1;
        end else if (ovf_c) begin
            spec_c = funct3[1] ? '0 : MIN_INT;
        end
        // Remainder takes the dividend sign; everything else takes sa^sb
        neg_c = (is_div_c && funct3[1]) ? sa_c : (sa_c ^ sb_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        iter_c   = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    accept_c = 1'b1;
                    state_d  = special_c ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    iter_c = 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d  = S_IDLE;
                finish_c = !flush;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One multiply step and one restoring-divide step per cycle
    logic [XLEN:0] mul_sum_c;
    logic [XLEN:0] rem_sh_c;
    logic [XLEN:0] rem_diff_c;

    always_comb begin
        mul_sum_c  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        rem_sh_c   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        rem_diff_c = rem_sh_c - {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else if (accept_c) begin
            cnt_q     <= '0;
            f3_q      <= funct3;
            rd_q      <= rd_in;
            a_q       <= abs_a_c;
            b_q       <= abs_b_c;
            neg_q     <= neg_c;
            special_q <= special_c;
            spec_q    <= spec_c;
            acc_q     <= {XLEN'(0), abs_b_c};
            rem_q     <= '0;
            quo_q     <= abs_a_c;
        end else if (iter_c) begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= {mul_sum_c, acc_q[XLEN-1:1]};
            if (!rem_diff_c[XLEN]) begin
                rem_q <= rem_diff_c;
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh_c;
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign fix and word select for the completing operation
    logic [PW-1:0]   prod_fix_c;
    logic [XLEN-1:0] quo_fix_c, rem_fix_c, res_c;

    always_comb begin
        prod_fix_c = neg_q ? ((~acc_q) + PW'(1)) : acc_q;
        quo_fix_c  = neg_q ? ((~quo_q) + XLEN'(1)) : quo_q;
        rem_fix_c  = neg_q ? ((~rem_q[XLEN-1:0]) + XLEN'(1)) : rem_q[XLEN-1:0];
        res_c      = '0;
        if (special_q) begin
            res_c = spec_q;
        end else begin
            case (f3_q)
                3'd0:             res_c = prod_fix_c[XLEN-1:0];
                3'd1, 3'd2, 3'd3: res_c = prod_fix_c[PW-1:XLEN];
                3'd4, 3'd5:       res_c = quo_fix_c;
                default:          res_c = rem_fix_c;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_en  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            busy  <= (state_d != S_IDLE);
            done  <= finish_c;
            wr_en <= finish_c && (rd_q != 5'd0);
            if (finish_c) begin
                result <= res_c;
                rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, latency,
// busy/start interaction, flush and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wr_en;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .wr_en  (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accept edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
        start   = 1'b0;
        op_a    = 32'h5A5A_A5A5;
        op_b    = 32'h0000_0003;
        rd_in   = 5'd17;
        funct3  = 3'd5;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n = 0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(cyc - acc_cyc), 32'(lat));
        chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(f, a, b, 5'd7);
        wait_done(tag, lat);
        chk({tag, " result"}, result, exp);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        bit          saw_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (2) @(negedge clk);
        chk("reset busy",   {31'd0, busy},   32'd0);
        chk("reset done",   {31'd0, done},   32'd0);
        chk("reset wr_en",  {31'd0, wr_en},  32'd0);
        chk("reset result", result,          32'd0);
        chk("reset rd_out", {27'd0, rd_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL with full latency and register-file handshake
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        chk("mul busy after accept", {31'd0, busy}, 32'd1);
        wait_done("mul", 33);
        chk("mul result", result, 32'hFFFF_FFEB);
        chk("mul rd_out", {27'd0, rd_out}, 32'd5);
        chk("mul wr_en",  {31'd0, wr_en},  32'd1);
        @(negedge clk);
        chk("mul done pulse", {31'd0, done}, 32'd0);

        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33);
        run_op("div0",   3'd4, 32'd10,        32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem0",   3'd6, 32'd10,        32'd0,         32'd10,        1);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // A start while busy must not disturb the op in flight
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        repeat (4) @(negedge clk);
        funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy-start", 33);
        chk("busy-start result", result, 32'hFFFF_FFEB);
        chk("busy-start rd_out", {27'd0, rd_out}, 32'd5);
        @(negedge clk);

        // rd=0 completes without a write, then a start on the done cycle is taken
        issue(3'd0, 32'd3, 32'd4, 5'd0);
        wait_done("rd0", 33);
        chk("rd0 result", result, 32'd12);
        chk("rd0 done",   {31'd0, done},  32'd1);
        chk("rd0 wr_en",  {31'd0, wr_en}, 32'd0);
        issue(3'd5, 32'd100, 32'd7, 5'd9);
        chk("b2b busy", {31'd0, busy}, 32'd1);
        chk("b2b done low", {31'd0, done}, 32'd0);
        wait_done("b2b", 33);
        chk("b2b result", result, 32'd14);
        chk("b2b rd_out", {27'd0, rd_out}, 32'd9);
        chk("b2b wr_en",  {31'd0, wr_en},  32'd1);
        @(negedge clk);

        // Flush mid-calculation: no done, result keeps old value
        held = result;
        issue(3'd0, 32'd5, 32'd6, 5'd4);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("flush no done", {31'd0, saw_done}, 32'd0);
        chk("flush result held", result, held);

        // Flush with start in IDLE: nothing is accepted
        funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush-start busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of CALC
        issue(3'd0, 32'd7, 32'd9, 5'd6);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy",   {31'd0, busy},   32'd0);
        chk("rst done",   {31'd0, done},   32'd0);
        chk("rst wr_en",  {31'd0, wr_en},  32'd0);
        chk("rst result", result,          32'd0);
        chk("rst rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("rst no done", {31'd0, saw_done}, 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
